// File: rtl/rb_pkg.sv
// Shared widths and types for the warp register block.
package rb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 64;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned NUM_WARPS = 8;
    localparam int unsigned WARP_W    = 3;
    localparam int unsigned NUM_LANES = 16;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [WARP_W-1:0]    warp_t;
    typedef logic [NUM_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/rb_lane_bank.sv
// One lane's register storage: all warp contexts, one write port, two
// combinational read ports that return zero when disabled.
module rb_lane_bank
    import rb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  warp_t warp_i,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  data_t wdata_i,
    input  logic  re0_i,
    input  addr_t raddr0_i,
    input  logic  re1_i,
    input  addr_t raddr1_i,
    output data_t rdata0_o,
    output data_t rdata1_o
);

    data_t mem_q [NUM_WARPS][NUM_REGS];

    // Async reset clears every word, so reads are zero throughout reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    mem_q[w][r] <= '0;
                end
            end
        end else if (we_i) begin
            mem_q[warp_i][waddr_i] <= wdata_i;
        end
    end

    // No write bypass: reads see the stored value until the edge.
    always_comb begin
        rdata0_o = '0;
        rdata1_o = '0;
        if (re0_i) rdata0_o = mem_q[warp_i][raddr0_i];
        if (re1_i) rdata1_o = mem_q[warp_i][raddr1_i];
    end

endmodule

// File: rtl/warp_register_block.sv
// Per-lane register file for a 16-lane SIMT core: 8 warps x 64 regs x 32 bits per lane,
// one shared-address write port and two shared-address read ports.
module warp_register_block
    import rb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WARP_W-1:0]    warp_selector,
    input  logic [NUM_LANES-1:0] write_en,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata_0,
    input  logic [DATA_W-1:0]    wdata_1,
    input  logic [DATA_W-1:0]    wdata_2,
    input  logic [DATA_W-1:0]    wdata_3,
    input  logic [DATA_W-1:0]    wdata_4,
    input  logic [DATA_W-1:0]    wdata_5,
    input  logic [DATA_W-1:0]    wdata_6,
    input  logic [DATA_W-1:0]    wdata_7,
    input  logic [DATA_W-1:0]    wdata_8,
    input  logic [DATA_W-1:0]    wdata_9,
    input  logic [DATA_W-1:0]    wdata_10,
    input  logic [DATA_W-1:0]    wdata_11,
    input  logic [DATA_W-1:0]    wdata_12,
    input  logic [DATA_W-1:0]    wdata_13,
    input  logic [DATA_W-1:0]    wdata_14,
    input  logic [DATA_W-1:0]    wdata_15,
    input  logic [NUM_LANES-1:0] read_en_0,
    input  logic [ADDR_W-1:0]    raddr_0,
    input  logic [NUM_LANES-1:0] read_en_1,
    input  logic [ADDR_W-1:0]    raddr_1,
    output logic [DATA_W-1:0]    rdata_0_0,
    output logic [DATA_W-1:0]    rdata_0_1,
    output logic [DATA_W-1:0]    rdata_0_2,
    output logic [DATA_W-1:0]    rdata_0_3,
    output logic [DATA_W-1:0]    rdata_0_4,
    output logic [DATA_W-1:0]    rdata_0_5,
    output logic [DATA_W-1:0]    rdata_0_6,
    output logic [DATA_W-1:0]    rdata_0_7,
    output logic [DATA_W-1:0]    rdata_0_8,
    output logic [DATA_W-1:0]    rdata_0_9,
    output logic [DATA_W-1:0]    rdata_0_10,
    output logic [DATA_W-1:0]    rdata_0_11,
    output logic [DATA_W-1:0]    rdata_0_12,
    output logic [DATA_W-1:0]    rdata_0_13,
    output logic [DATA_W-1:0]    rdata_0_14,
    output logic [DATA_W-1:0]    rdata_0_15,
    output logic [DATA_W-1:0]    rdata_1_0,
    output logic [DATA_W-1:0]    rdata_1_1,
    output logic [DATA_W-1:0]    rdata_1_2,
    output logic [DATA_W-1:0]    rdata_1_3,
    output logic [DATA_W-1:0]    rdata_1_4,
    output logic [DATA_W-1:0]    rdata_1_5,
    output logic [DATA_W-1:0]    rdata_1_6,
    output logic [DATA_W-1:0]    rdata_1_7,
    output logic [DATA_W-1:0]    rdata_1_8,
    output logic [DATA_W-1:0]    rdata_1_9,
    output logic [DATA_W-1:0]    rdata_1_10,
    output logic [DATA_W-1:0]    rdata_1_11,
    output logic [DATA_W-1:0]    rdata_1_12,
    output logic [DATA_W-1:0]    rdata_1_13,
    output logic [DATA_W-1:0]    rdata_1_14,
    output logic [DATA_W-1:0]    rdata_1_15
);

    data_t wdata_lane  [NUM_LANES];
    data_t rdata0_lane [NUM_LANES];
    data_t rdata1_lane [NUM_LANES];

    // Flat per-lane ports onto lane-indexed arrays.
    assign wdata_lane[0]  = wdata_0;
    assign wdata_lane[1]  = wdata_1;
    assign wdata_lane[2]  = wdata_2;
    assign wdata_lane[3]  = wdata_3;
    assign wdata_lane[4]  = wdata_4;
    assign wdata_lane[5]  = wdata_5;
    assign wdata_lane[6]  = wdata_6;
    assign wdata_lane[7]  = wdata_7;
    assign wdata_lane[8]  = wdata_8;
    assign wdata_lane[9]  = wdata_9;
    assign wdata_lane[10] = wdata_10;
    assign wdata_lane[11] = wdata_11;
    assign wdata_lane[12] = wdata_12;
    assign wdata_lane[13] = wdata_13;
    assign wdata_lane[14] = wdata_14;
    assign wdata_lane[15] = wdata_15;

    assign rdata_0_0  = rdata0_lane[0];
    assign rdata_0_1  = rdata0_lane[1];
    assign rdata_0_2  = rdata0_lane[2];
    assign rdata_0_3  = rdata0_lane[3];
    assign rdata_0_4  = rdata0_lane[4];
    assign rdata_0_5  = rdata0_lane[5];
    assign rdata_0_6  = rdata0_lane[6];
    assign rdata_0_7  = rdata0_lane[7];
    assign rdata_0_8  = rdata0_lane[8];
    assign rdata_0_9  = rdata0_lane[9];
    assign rdata_0_10 = rdata0_lane[10];
    assign rdata_0_11 = rdata0_lane[11];
    assign rdata_0_12 = rdata0_lane[12];
    assign rdata_0_13 = rdata0_lane[13];
    assign rdata_0_14 = rdata0_lane[14];
    assign rdata_0_15 = rdata0_lane[15];

    assign rdata_1_0  = rdata1_lane[0];
    assign rdata_1_1  = rdata1_lane[1];
    assign rdata_1_2  = rdata1_lane[2];
    assign rdata_1_3  = rdata1_lane[3];
    assign rdata_1_4  = rdata1_lane[4];
    assign rdata_1_5  = rdata1_lane[5];
    assign rdata_1_6  = rdata1_lane[6];
    assign rdata_1_7  = rdata1_lane[7];
    assign rdata_1_8  = rdata1_lane[8];
    assign rdata_1_9  = rdata1_lane[9];
    assign rdata_1_10 = rdata1_lane[10];
    assign rdata_1_11 = rdata1_lane[11];
    assign rdata_1_12 = rdata1_lane[12];
    assign rdata_1_13 = rdata1_lane[13];
    assign rdata_1_14 = rdata1_lane[14];
    assign rdata_1_15 = rdata1_lane[15];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rb_lane_bank u_bank (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .warp_i   (warp_selector),
            .we_i     (write_en[l]),
            .waddr_i  (waddr),
            .wdata_i  (wdata_lane[l]),
            .re0_i    (read_en_0[l]),
            .raddr0_i (raddr_0),
            .re1_i    (read_en_1[l]),
            .raddr1_i (raddr_1),
            .rdata0_o (rdata0_lane[l]),
            .rdata1_o (rdata1_lane[l])
        );
    end

endmodule

// File: tb/tb_warp_register_block.sv
// Directed bench for warp_register_block: reset, gating, warp isolation, sweep, same-cycle RAW.
module tb_warp_register_block;

    logic        clk;
    logic        rst_n;
    logic [2:0]  warp_selector;
    logic [15:0] write_en;
    logic [5:0]  waddr;
    logic [31:0] wdata [16];
    logic [15:0] read_en_0;
    logic [5:0]  raddr_0;
    logic [15:0] read_en_1;
    logic [5:0]  raddr_1;
    wire  [31:0] rd0 [16];
    wire  [31:0] rd1 [16];

    int n_checks;
    int n_errors;
    logic [31:0] model [8][64][16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    warp_register_block dut (
        .clk(clk), .rst_n(rst_n), .warp_selector(warp_selector), .write_en(write_en),
        .waddr(waddr),
        .wdata_0(wdata[0]),   .wdata_1(wdata[1]),   .wdata_2(wdata[2]),   .wdata_3(wdata[3]),
        .wdata_4(wdata[4]),   .wdata_5(wdata[5]),   .wdata_6(wdata[6]),   .wdata_7(wdata[7]),
        .wdata_8(wdata[8]),   .wdata_9(wdata[9]),   .wdata_10(wdata[10]), .wdata_11(wdata[11]),
        .wdata_12(wdata[12]), .wdata_13(wdata[13]), .wdata_14(wdata[14]), .wdata_15(wdata[15]),
        .read_en_0(read_en_0), .raddr_0(raddr_0), .read_en_1(read_en_1), .raddr_1(raddr_1),
        .rdata_0_0(rd0[0]),   .rdata_0_1(rd0[1]),   .rdata_0_2(rd0[2]),   .rdata_0_3(rd0[3]),
        .rdata_0_4(rd0[4]),   .rdata_0_5(rd0[5]),   .rdata_0_6(rd0[6]),   .rdata_0_7(rd0[7]),
        .rdata_0_8(rd0[8]),   .rdata_0_9(rd0[9]),   .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
        .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
        .rdata_1_0(rd1[0]),   .rdata_1_1(rd1[1]),   .rdata_1_2(rd1[2]),   .rdata_1_3(rd1[3]),
        .rdata_1_4(rd1[4]),   .rdata_1_5(rd1[5]),   .rdata_1_6(rd1[6]),   .rdata_1_7(rd1[7]),
        .rdata_1_8(rd1[8]),   .rdata_1_9(rd1[9]),   .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
        .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
    );

    task automatic check(input string tag, input int lane, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s lane %0d: got %h expected %h", tag, lane, got, exp);
        end
    endtask

    task automatic set_read(input logic [15:0] e0, input logic [5:0] a0,
                            input logic [15:0] e1, input logic [5:0] a1);
        read_en_0 = e0;
        raddr_0   = a0;
        read_en_1 = e1;
        raddr_1   = a1;
        #1;
    endtask

    // Drive a write away from the edge, then drop the enable 1 ns after it.
    task automatic do_write(input logic [2:0] w, input logic [5:0] a, input logic [15:0] en);
        @(negedge clk);
        warp_selector = w;
        waddr         = a;
        write_en      = en;
        @(posedge clk);
        #1;
        write_en = '0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b1;
        warp_selector = '0;
        write_en      = '0;
        waddr         = '0;
        read_en_0     = '0;
        raddr_0       = '0;
        read_en_1     = '0;
        raddr_1       = '0;
        for (int l = 0; l < 16; l++) wdata[l] = '0;
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 64; r++)
                for (int l = 0; l < 16; l++) model[w][r][l] = '0;

        // Reset: all outputs zero whatever the enables
        #2 rst_n = 1'b0;
        set_read(16'hFFFF, 6'd0, 16'hFFFF, 6'd63);
        for (int l = 0; l < 16; l++) begin
            check("reset_p0", l, rd0[l], 32'h0);
            check("reset_p1", l, rd1[l], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        warp_selector = 3'd3;
        set_read(16'hFFFF, 6'd17, 16'hFFFF, 6'd17);
        for (int l = 0; l < 16; l++) check("post_reset_w3r17", l, rd0[l], 32'h0);

        // All-lane write/read, warp 0 reg 5
        for (int l = 0; l < 16; l++) wdata[l] = 32'hA000_0000 + l;
        do_write(3'd0, 6'd5, 16'hFFFF);
        set_read(16'hFFFF, 6'd5, 16'h0000, 6'd0);
        for (int l = 0; l < 16; l++) begin
            check("all_p0", l, rd0[l], 32'hA000_0000 + l);
            check("all_p1_off", l, rd1[l], 32'h0);
        end
        set_read(16'h0000, 6'd0, 16'hFFFF, 6'd5);
        for (int l = 0; l < 16; l++) check("all_p1", l, rd1[l], 32'hA000_0000 + l);
        set_read(16'hFFFF, 6'd5, 16'hFFFF, 6'd5);
        for (int l = 0; l < 16; l++) begin
            check("all_both_p0", l, rd0[l], 32'hA000_0000 + l);
            check("all_both_p1", l, rd1[l], 32'hA000_0000 + l);
        end

        // Enable gating on write and on read
        for (int l = 0; l < 16; l++) wdata[l] = 32'hB000_0000 + l;
        do_write(3'd0, 6'd5, 16'h00FF);
        set_read(16'hFFFF, 6'd5, 16'h0F0F, 6'd5);
        for (int l = 0; l < 16; l++) begin
            check("gate_wr_p0", l, rd0[l], (l < 8) ? 32'hB000_0000 + l : 32'hA000_0000 + l);
            check("gate_rd_p1", l, rd1[l],
                  ((l % 8) >= 4) ? 32'h0 : ((l < 8) ? 32'hB000_0000 + l : 32'hA000_0000 + l));
        end

        // Warp isolation
        for (int l = 0; l < 16; l++) wdata[l] = 32'hDEADBEEF;
        do_write(3'd2, 6'd9, 16'hFFFF);
        warp_selector = 3'd3;
        set_read(16'hFFFF, 6'd9, 16'hFFFF, 6'd9);
        for (int l = 0; l < 16; l++) check("iso_w3", l, rd0[l], 32'h0);
        warp_selector = 3'd2;
        set_read(16'hFFFF, 6'd9, 16'hFFFF, 6'd9);
        for (int l = 0; l < 16; l++) check("iso_w2", l, rd1[l], 32'hDEADBEEF);

        // Sweep every warp and register with random data on lanes 0-7
        for (int w = 0; w < 8; w++) begin
            for (int r = 0; r < 64; r++) begin
                for (int k = 0; k < 10; k++) begin
                    for (int l = 0; l < 16; l++) begin
                        wdata[l] = (l < 8) ? $urandom : 32'h0;
                        model[w][r][l] = wdata[l];
                    end
                    do_write(w[2:0], r[5:0], 16'hFFFF);
                    set_read(16'hFFFF, r[5:0], 16'h0000, 6'd0);
                    for (int l = 0; l < 16; l++) check("sweep_p0", l, rd0[l], model[w][r][l]);
                    set_read(16'h0000, 6'd0, 16'hFFFF, r[5:0]);
                    for (int l = 0; l < 16; l++) check("sweep_p1", l, rd1[l], model[w][r][l]);
                    set_read(16'hFFFF, r[5:0], 16'hFFFF, r[5:0]);
                    for (int l = 0; l < 16; l++) begin
                        check("sweep_b0", l, rd0[l], model[w][r][l]);
                        check("sweep_b1", l, rd1[l], model[w][r][l]);
                    end
                end
            end
        end

        // Full readback catches writes that leaked into other warps/registers
        for (int w = 0; w < 8; w++) begin
            warp_selector = w[2:0];
            for (int r = 0; r < 64; r++) begin
                set_read(16'hFFFF, r[5:0], 16'hFFFF, 6'(63 - r));
                for (int l = 0; l < 16; l++) begin
                    check("final_p0", l, rd0[l], model[w][r][l]);
                    check("final_p1", l, rd1[l], model[w][63-r][l]);
                end
            end
        end

        // Same-cycle read/write: old value before the edge, new after
        for (int l = 0; l < 16; l++) wdata[l] = 32'h1;
        do_write(3'd1, 6'd12, 16'hFFFF);
        @(negedge clk);
        for (int l = 0; l < 16; l++) wdata[l] = 32'h2;
        waddr    = 6'd12;
        write_en = 16'hFFFF;
        set_read(16'hFFFF, 6'd12, 16'h0000, 6'd0);
        for (int l = 0; l < 16; l++) check("raw_before", l, rd0[l], 32'h1);
        @(posedge clk);
        #1;
        write_en = '0;
        for (int l = 0; l < 16; l++) check("raw_after", l, rd0[l], 32'h2);

        // Mid-cycle reset clears at once and blocks writes while low
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 16; l++) check("async_rst", l, rd0[l], 32'h0);
        for (int l = 0; l < 16; l++) wdata[l] = 32'h3;
        write_en = 16'hFFFF;
        @(posedge clk);
        #1;
        for (int l = 0; l < 16; l++) check("rst_wr_ignored", l, rd0[l], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int l = 0; l < 16; l++) check("rst_release", l, rd0[l], 32'h0);
        @(posedge clk);
        #1;
        write_en = '0;
        for (int l = 0; l < 16; l++) check("first_wr_after_rst", l, rd0[l], 32'h3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/warp_register_block.md
# warp_register_block

Per-lane register file for a 16-lane SIMT core. It holds 64 × 32-bit registers per lane for each of 8 warps. Each lane has one write port and two independent combinational read ports, and a 3-bit warp selector picks the active warp context. It sits between the operand-collect stage, which reads through ports 0 and 1, and the writeback stage, which uses the write port.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_REGS, 64, registers per lane per warp; address width ADDR_W = 6
- NUM_WARPS, 8, warp contexts; selector width 3
- NUM_LANES, 16, lane count; fixed by the per-lane port list

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- warp_selector  in  3  active warp for all reads and the write
- write_en  in  16  per-lane write enable, bit l → lane l
- waddr  in  6  write register address, shared by all lanes
- wdata_0 … wdata_15  in  32 each  write data for lane l
- read_en_0  in  16  per-lane enable, read port 0
- raddr_0  in  6  read address, port 0, shared by all lanes
- read_en_1  in  16  per-lane enable, read port 1
- raddr_1  in  6  read address, port 1
- rdata_0_0 … rdata_0_15  out  32 each  port-0 read data for lane l
- rdata_1_0 … rdata_1_15  out  32 each  port-1 read data for lane l

## Operation
- Storage is mem[warp][lane][reg], 8 × 16 × 64 words of 32 bits.
- Write: on rising clk with rst_n high, for each lane l with write_en[l]=1, mem[warp_selector][l][waddr] ← wdata_l. Lanes with enable 0 are unchanged. The other warps are never touched.
- Read port p, lane l: if read_en_p[l]=1, rdata_p_l = mem[warp_selector][l][raddr_p]. Otherwise rdata_p_l = 0.
- Both ports may address the same or different registers simultaneously with no conflict.
- There is no register 0 hardwiring; all 64 addresses are writable.
- Reset (rst_n=0): every storage word clears to 0 immediately. Because of this, all rdata outputs are 0 during reset, whatever the enables.

## Timing
- Write latency: 1 edge. Data written at edge N is readable combinationally right after edge N.
- Read: purely combinational from address, enable and warp_selector. There is no clock on the read path, and the outputs settle within the same cycle.
- Read and write of the same address in the same cycle: the read returns the pre-edge (old) value until the edge, then the new value. There is no wdata→rdata bypass.
- Changing warp_selector re-maps reads immediately. A write uses the warp_selector value sampled at the edge.
- Reset asserted mid-operation clears storage asynchronously. Writes are ignored while rst_n=0. The first write takes effect on the first rising edge after deassertion.
- Address wrap: addresses are 6-bit, so no out-of-range case exists.

## Structure
- Shared package rb_pkg: DATA_W, NUM_REGS, ADDR_W, NUM_WARPS, WARP_W, NUM_LANES, and typedefs data_t, addr_t, warp_t.
- One sub-module, rb_lane_bank: one lane's 8×64×32 array with async reset, 1 write port, 2 async-read ports, and enable gating to 0.
- The top generates 16 instances and maps the flat wdata_l / rdata_p_l ports onto them.

## Test plan
- Reset: hold rst_n=0, set read_en_0=read_en_1=16'hFFFF at any address → all 32 rdata = 0. Release reset and read warp 3 reg 17 → 0.
- All-lane write/read: warp 0, waddr=6'h05, write_en=16'hFFFF, wdata_l=32'hA000_0000+l, one edge. Then read_en_0=16'hFFFF, raddr_0=5 → rdata_0_l = 32'hA000_0000+l. Repeat on port 1, then on both ports at once → identical values.
- Enable gating: write_en=16'h00FF with new data → lanes 8–15 keep old values. read_en_1=16'h0F0F → lanes with disabled bits read 0.
- Warp isolation: write 32'hDEADBEEF to reg 9 in warp 2 for all lanes. Set warp_selector=3 → reg 9 reads 0. Set back to 2 → DEADBEEF.
- Sweep: for warps 0–7 × regs 0–63, write 10 random values per register on all 16 lanes (lanes 8–15 data 0). Check port 0, port 1 and both ports after each write → every value matches the last write.
- Same-cycle read/write: hold raddr_0=waddr=12 with old value 32'h1 and write 32'h2 → rdata_0 = 1 before the edge and 2 after it. Assert rst_n=0 between edges → outputs 0 immediately.
